// File: rtl/io_sw_debounce.sv
// Switch-pin conditioner: two-flop synchroniser, shared sample-tick prescaler,
// per-bit N-sample debounce, and a sticky software-clearable change mask.
module io_sw_debounce #(
   parameter int WIDTH      = 32,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_sw_raw,
   input  logic             i_clr_change,
   output logic [WIDTH-1:0] o_io_sw,
   output logic [WIDTH-1:0] o_sw_change_mask,
   output logic             o_sw_changed
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam int HW = STABLE_CNT - 1;

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             tick;
   logic [WIDTH-1:0] io_sw_q;
   logic [WIDTH-1:0] io_sw_d;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_sw_raw;
         sync2_q <= sync1_q;
      end
   end

   assign tick  = (cnt_q == CNT_MAX);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [HW-1:0] hist_q;
         logic [HW-1:0] hist_d;
         logic          all_one;
         logic          all_zero;

         // The window includes the current synchronised sample, so only
         // STABLE_CNT-1 older samples need storage.
         if (HW == 1) begin : g_h1
            assign hist_d = sync2_q[gi];
         end else begin : g_hn
            assign hist_d = {hist_q[HW-2:0], sync2_q[gi]};
         end

         assign all_one  =  (&{hist_q, sync2_q[gi]});
         assign all_zero = ~(|{hist_q, sync2_q[gi]});

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset)  hist_q <= '0;
            else if (tick) hist_q <= hist_d;
         end

         always_comb begin
            io_sw_d[gi] = io_sw_q[gi];
            if (tick) begin
               if (all_one)       io_sw_d[gi] = 1'b1;
               else if (all_zero) io_sw_d[gi] = 1'b0;
            end
         end
      end
   endgenerate

   // A toggle on the same edge as a clear wins for that bit.
   assign mask_d = (i_clr_change ? '0 : mask_q) | (io_sw_d ^ io_sw_q);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         io_sw_q <= '0;
         mask_q  <= '0;
      end else begin
         io_sw_q <= io_sw_d;
         mask_q  <= mask_d;
      end
   end

   assign o_io_sw          = io_sw_q;
   assign o_sw_change_mask = mask_q;
   assign o_sw_changed     = |mask_q;

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce with TICK_DIV=4, STABLE_CNT=3.
// Edge numbers count rising edges after reset release.
module tb_io_sw_debounce;

   logic        i_clk;
   logic        i_reset;
   logic [31:0] i_sw_raw;
   logic        i_clr_change;
   logic [31:0] o_io_sw;
   logic [31:0] o_sw_change_mask;
   logic        o_sw_changed;

   int checks;
   int errors;

   io_sw_debounce #(
      .WIDTH      (32),
      .TICK_DIV   (4),
      .STABLE_CNT (3)
   ) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_sw_raw         (i_sw_raw),
      .i_clr_change     (i_clr_change),
      .o_io_sw          (o_io_sw),
      .o_sw_change_mask (o_sw_change_mask),
      .o_sw_changed     (o_sw_changed)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance n rising edges and settle just after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Reset with the given raw word applied; returns 1 time unit after the
   // release, so the next rising edge is edge 1.
   task automatic do_reset(input logic [31:0] raw);
      i_reset      = 1'b0;
      i_clr_change = 1'b0;
      i_sw_raw     = raw;
      step(3);
      i_reset = 1'b1;
   endtask

   task automatic test_reset;
      i_reset      = 1'b0;
      i_clr_change = 1'b0;
      i_sw_raw     = 32'hFFFF_FFFF;
      step(20);
      checks++;
      if (o_io_sw !== 32'h0) begin
         errors++;
         $display("FAIL reset_io_sw: got %h expected %h", o_io_sw, 32'h0);
      end
      checks++;
      if (o_sw_change_mask !== 32'h0) begin
         errors++;
         $display("FAIL reset_mask: got %h expected %h", o_sw_change_mask, 32'h0);
      end
      checks++;
      if (o_sw_changed !== 1'b0) begin
         errors++;
         $display("FAIL reset_changed: got %b expected 0", o_sw_changed);
      end
      $display("reset: io_sw=%h mask=%h changed=%b", o_io_sw, o_sw_change_mask, o_sw_changed);
   endtask

   task automatic test_clean_rise;
      do_reset(32'h0);
      i_sw_raw = 32'h0000_0001;
      step(11);
      checks++;
      if (o_io_sw !== 32'h0) begin
         errors++;
         $display("FAIL rise_edge11_io_sw: got %h expected %h", o_io_sw, 32'h0);
      end
      step(1);
      checks++;
      if (o_io_sw !== 32'h0000_0001) begin
         errors++;
         $display("FAIL rise_edge12_io_sw: got %h expected %h", o_io_sw, 32'h1);
      end
      checks++;
      if (o_sw_change_mask !== 32'h0000_0001) begin
         errors++;
         $display("FAIL rise_edge12_mask: got %h expected %h", o_sw_change_mask, 32'h1);
      end
      checks++;
      if (o_sw_changed !== 1'b1) begin
         errors++;
         $display("FAIL rise_edge12_changed: got %b expected 1", o_sw_changed);
      end
      $display("clean_rise: io_sw=%h mask=%h changed=%b", o_io_sw, o_sw_change_mask, o_sw_changed);
   endtask

   task automatic test_glitch_reject;
      int bad;
      bad = 0;
      do_reset(32'h0);
      i_sw_raw = 32'h0000_0020;
      step(5);
      i_sw_raw = 32'h0;
      for (int c = 0; c < 40; c++) begin
         step(1);
         checks++;
         if (o_io_sw !== 32'h0 || o_sw_change_mask !== 32'h0) begin
            errors++;
            bad++;
            $display("FAIL glitch_cycle%0d: io_sw=%h mask=%h expected 0/0", c, o_io_sw, o_sw_change_mask);
         end
      end
      $display("glitch_reject: io_sw=%h mask=%h bad_cycles=%0d", o_io_sw, o_sw_change_mask, bad);
   endtask

   task automatic test_multi_bit_fall;
      do_reset(32'h0);
      i_sw_raw = 32'hA5A5_A5A5;
      step(12);
      checks++;
      if (o_io_sw !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL multi_settle_io_sw: got %h expected %h", o_io_sw, 32'hA5A5_A5A5);
      end
      checks++;
      if (o_sw_change_mask !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL multi_settle_mask: got %h expected %h", o_sw_change_mask, 32'hA5A5_A5A5);
      end
      i_clr_change = 1'b1;
      step(1);
      i_clr_change = 1'b0;
      checks++;
      if (o_sw_change_mask !== 32'h0) begin
         errors++;
         $display("FAIL multi_clr1_mask: got %h expected %h", o_sw_change_mask, 32'h0);
      end
      // After edge 13: new level reaches sync2 at edge 15, ticks 16/20/24.
      i_sw_raw = 32'h5A5A_5A5A;
      step(10);
      checks++;
      if (o_io_sw !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL multi_edge23_io_sw: got %h expected %h", o_io_sw, 32'hA5A5_A5A5);
      end
      step(1);
      checks++;
      if (o_io_sw !== 32'h5A5A_5A5A) begin
         errors++;
         $display("FAIL multi_edge24_io_sw: got %h expected %h", o_io_sw, 32'h5A5A_5A5A);
      end
      checks++;
      if (o_sw_change_mask !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL multi_edge24_mask: got %h expected %h", o_sw_change_mask, 32'hFFFF_FFFF);
      end
      checks++;
      if (o_sw_changed !== 1'b1) begin
         errors++;
         $display("FAIL multi_edge24_changed: got %b expected 1", o_sw_changed);
      end
      i_clr_change = 1'b1;
      step(1);
      i_clr_change = 1'b0;
      checks++;
      if (o_sw_change_mask !== 32'h0 || o_sw_changed !== 1'b0) begin
         errors++;
         $display("FAIL multi_clr2: mask=%h changed=%b expected 0/0", o_sw_change_mask, o_sw_changed);
      end
      $display("multi_bit_fall: io_sw=%h mask=%h changed=%b", o_io_sw, o_sw_change_mask, o_sw_changed);
   endtask

   task automatic test_set_clear_collision;
      do_reset(32'h0);
      i_sw_raw = 32'h0000_0100;
      step(12);
      checks++;
      if (o_sw_change_mask !== 32'h0000_0100) begin
         errors++;
         $display("FAIL coll_pre_mask: got %h expected %h", o_sw_change_mask, 32'h100);
      end
      // Bit 3 reaches sync2 at edge 14, accepted on the tick at edge 24.
      i_sw_raw = 32'h0000_0108;
      step(11);
      checks++;
      if (o_io_sw !== 32'h0000_0100) begin
         errors++;
         $display("FAIL coll_edge23_io_sw: got %h expected %h", o_io_sw, 32'h100);
      end
      i_clr_change = 1'b1;
      step(1);
      i_clr_change = 1'b0;
      checks++;
      if (o_io_sw !== 32'h0000_0108) begin
         errors++;
         $display("FAIL coll_edge24_io_sw: got %h expected %h", o_io_sw, 32'h108);
      end
      checks++;
      if (o_sw_change_mask !== 32'h0000_0008) begin
         errors++;
         $display("FAIL coll_edge24_mask: got %h expected %h", o_sw_change_mask, 32'h8);
      end
      checks++;
      if (o_sw_changed !== 1'b1) begin
         errors++;
         $display("FAIL coll_edge24_changed: got %b expected 1", o_sw_changed);
      end
      $display("set_clear_collision: io_sw=%h mask=%h", o_io_sw, o_sw_change_mask);
   endtask

   task automatic test_reset_mid_accept;
      do_reset(32'h0);
      i_sw_raw = 32'h0000_0080;
      step(8);
      checks++;
      if (o_io_sw !== 32'h0) begin
         errors++;
         $display("FAIL midrst_pre_io_sw: got %h expected %h", o_io_sw, 32'h0);
      end
      i_reset = 1'b0;
      step(1);
      checks++;
      if (o_io_sw !== 32'h0 || o_sw_change_mask !== 32'h0) begin
         errors++;
         $display("FAIL midrst_during: io_sw=%h mask=%h expected 0/0", o_io_sw, o_sw_change_mask);
      end
      i_reset = 1'b1;
      step(11);
      checks++;
      if (o_io_sw !== 32'h0) begin
         errors++;
         $display("FAIL midrst_edge11_io_sw: got %h expected %h", o_io_sw, 32'h0);
      end
      step(1);
      checks++;
      if (o_io_sw !== 32'h0000_0080) begin
         errors++;
         $display("FAIL midrst_edge12_io_sw: got %h expected %h", o_io_sw, 32'h80);
      end
      checks++;
      if (o_sw_change_mask !== 32'h0000_0080) begin
         errors++;
         $display("FAIL midrst_edge12_mask: got %h expected %h", o_sw_change_mask, 32'h80);
      end
      $display("reset_mid_accept: io_sw=%h mask=%h", o_io_sw, o_sw_change_mask);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      i_reset      = 1'b0;
      i_sw_raw     = 32'h0;
      i_clr_change = 1'b0;
      #1;
      test_reset();
      test_clean_rise();
      test_glitch_reject();
      test_multi_bit_fall();
      test_set_clear_collision();
      test_reset_mid_accept();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
